// File: rtl/wb_retire_stage.sv
// Write-back retire stage: in-order retire queue between MEM and the register file,
// with load alignment, HI/LO update at retire, $0 suppression and youngest-match forwarding.
module wb_retire_stage #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              wb_allowin,
  input  logic [31:0]       mem_pc,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [3:0]        mem_wen,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              mem_is_load,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_hi_we,
  input  logic              mem_lo_we,
  input  logic [DATA_W-1:0] mem_hi_wdata,
  input  logic [DATA_W-1:0] mem_lo_wdata,
  input  logic              rf_ready,
  output logic [3:0]        rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  input  logic [ADDR_W-1:0] fwd_raddr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              wb_valid,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  logic [31:0]       q_pc      [DEPTH];
  logic [ADDR_W-1:0] q_waddr   [DEPTH];
  logic [3:0]        q_wen     [DEPTH];
  logic [DATA_W-1:0] q_data    [DEPTH];
  logic              q_hi_we   [DEPTH];
  logic              q_lo_we   [DEPTH];
  logic [DATA_W-1:0] q_hi_data [DEPTH];
  logic [DATA_W-1:0] q_lo_data [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              enq;
  logic              deq;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] enq_data;
  logic [3:0]        enq_wen;
  logic [PTR_W-1:0]  fwd_idx;

  assign wb_allowin = (count != CNT_W'(DEPTH));
  assign wb_valid   = (count != '0);
  assign enq        = mem_valid & wb_allowin;
  assign deq        = wb_valid & rf_ready;

  // Load-data alignment and extension
  always_comb begin
    byte_sel  = mem_rdata[7:0];
    half_sel  = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (mem_addr_lo)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    case (mem_load_type)
      LT_LB:   load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LT_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LT_LH:   load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LT_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Loads write the whole register; $0 writes are dropped but still retire
  always_comb begin
    enq_data = mem_is_load ? load_data : mem_result;
    enq_wen  = mem_wen;
    if (mem_is_load) begin
      enq_wen = (mem_wen != 4'h0) ? 4'hF : 4'h0;
    end
    if (mem_waddr == '0) begin
      enq_wen = 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[wr_ptr]      <= mem_pc;
      q_waddr[wr_ptr]   <= mem_waddr;
      q_wen[wr_ptr]     <= enq_wen;
      q_data[wr_ptr]    <= enq_data;
      q_hi_we[wr_ptr]   <= mem_hi_we;
      q_lo_we[wr_ptr]   <= mem_lo_we;
      q_hi_data[wr_ptr] <= mem_hi_wdata;
      q_lo_data[wr_ptr] <= mem_lo_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (q_hi_we[rd_ptr]) begin
          hi_o <= q_hi_data[rd_ptr];
        end
        if (q_lo_we[rd_ptr]) begin
          lo_o <= q_lo_data[rd_ptr];
        end
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rf_wen   = deq ? q_wen[rd_ptr] : 4'h0;
  assign rf_waddr = wb_valid ? q_waddr[rd_ptr] : '0;
  assign rf_wdata = wb_valid ? q_data[rd_ptr] : '0;

  assign debug_wb_pc       = wb_valid ? q_pc[rd_ptr] : 32'h0;
  assign debug_wb_rf_wen   = rf_wen;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // Walk oldest to youngest so the last match wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (fwd_raddr != '0) &&
          (q_waddr[fwd_idx] == fwd_raddr) && (q_wen[fwd_idx] != 4'h0)) begin
        fwd_hit  = 1'b1;
        fwd_data = q_data[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed bench for wb_retire_stage: reset, retire timing, back-pressure,
// load alignment, $0 suppression, HI update and forwarding.
module tb_wb_retire_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        wb_allowin;
  logic [31:0] mem_pc;
  logic [4:0]  mem_waddr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_result;
  logic        mem_is_load;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_rdata;
  logic        mem_hi_we;
  logic        mem_lo_we;
  logic [31:0] mem_hi_wdata;
  logic [31:0] mem_lo_wdata;
  logic        rf_ready;
  logic [3:0]  rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [4:0]  fwd_raddr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        wb_valid;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_retire_stage #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .wb_allowin(wb_allowin),
    .mem_pc(mem_pc), .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_result(mem_result),
    .mem_is_load(mem_is_load), .mem_load_type(mem_load_type), .mem_addr_lo(mem_addr_lo),
    .mem_rdata(mem_rdata), .mem_hi_we(mem_hi_we), .mem_lo_we(mem_lo_we),
    .mem_hi_wdata(mem_hi_wdata), .mem_lo_wdata(mem_lo_wdata), .rf_ready(rf_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi_o(hi_o), .lo_o(lo_o),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .wb_valid(wb_valid),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit after that
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_pc = 0; mem_waddr = 0; mem_wen = 0; mem_result = 0;
    mem_is_load = 0; mem_load_type = 0; mem_addr_lo = 0; mem_rdata = 0;
    mem_hi_we = 0; mem_lo_we = 0; mem_hi_wdata = 0; mem_lo_wdata = 0;
  endtask

  task automatic drive_alu(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] res);
    mem_valid = 1; mem_pc = pc; mem_waddr = wa; mem_wen = 4'hF; mem_result = res;
    mem_is_load = 0; mem_hi_we = 0; mem_lo_we = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); rf_ready = 0; fwd_raddr = 0;
    reset = 1;
    #12;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b want 1", wb_allowin); end
    checks++; if (rf_wen !== 4'h0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin errors++;
      $display("FAIL reset_rf: got wen=%h waddr=%0d wdata=%h want all 0", rf_wen, rf_waddr, rf_wdata); end
    checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin errors++; $display("FAIL reset_hilo: got hi=%h lo=%h want 0", hi_o, lo_o); end
    checks++; if (debug_wb_pc !== 32'h0 || fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin errors++;
      $display("FAIL reset_dbg_fwd: got pc=%h hit=%b fdata=%h want 0", debug_wb_pc, fwd_hit, fwd_data); end
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    rf_ready = 1;
    drive_alu(32'hbfc00000, 5'd3, 32'd5);
    tick();
    drive_alu(32'hbfc00004, 5'd4, 32'd7);
    #1;
    checks++; if (rf_wen !== 4'hF || rf_waddr !== 5'd3 || rf_wdata !== 32'd5) begin errors++;
      $display("FAIL b2b_first: got wen=%h waddr=%0d wdata=%h want F/3/5", rf_wen, rf_waddr, rf_wdata); end
    checks++; if (debug_wb_pc !== 32'hbfc00000 || debug_wb_rf_wnum !== 5'd3 || debug_wb_rf_wen !== 4'hF || debug_wb_rf_wdata !== 32'd5) begin errors++;
      $display("FAIL b2b_trace: got pc=%h wnum=%0d wen=%h wdata=%h", debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wen, debug_wb_rf_wdata); end
    tick();
    idle_inputs();
    #1;
    checks++; if (rf_wen !== 4'hF || rf_waddr !== 5'd4 || rf_wdata !== 32'd7 || debug_wb_pc !== 32'hbfc00004) begin errors++;
      $display("FAIL b2b_second: got wen=%h waddr=%0d wdata=%h pc=%h want F/4/7/bfc00004", rf_wen, rf_waddr, rf_wdata, debug_wb_pc); end
    tick();
    checks++; if (wb_valid !== 1'b0 || rf_wen !== 4'h0) begin errors++;
      $display("FAIL b2b_drain: got valid=%b wen=%h want 0/0", wb_valid, rf_wen); end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp_addr [3];
    exp_addr[0] = 5'd10; exp_addr[1] = 5'd11; exp_addr[2] = 5'd12;
    rf_ready = 0;
    drive_alu(32'h100, 5'd10, 32'hA);
    #1;
    checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL bp_allow0: got %b want 1", wb_allowin); end
    tick();
    drive_alu(32'h104, 5'd11, 32'hB);
    #1;
    checks++; if (wb_allowin !== 1'b1 || rf_wen !== 4'h0) begin errors++;
      $display("FAIL bp_allow1: got allow=%b wen=%h want 1/0", wb_allowin, rf_wen); end
    tick();
    drive_alu(32'h108, 5'd12, 32'hC);
    #1;
    checks++; if (wb_allowin !== 1'b0 || wb_valid !== 1'b1) begin errors++;
      $display("FAIL bp_full: got allow=%b valid=%b want 0/1", wb_allowin, wb_valid); end
    tick();
    rf_ready = 1;
    #1;
    checks++; if (wb_allowin !== 1'b0) begin errors++; $display("FAIL bp_allow_indep: got %b want 0", wb_allowin); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rf_wen !== 4'hF || rf_waddr !== exp_addr[i] || rf_wdata !== 32'(10 + i)) begin errors++;
        $display("FAIL bp_order%0d: got wen=%h waddr=%0d wdata=%h want F/%0d/%h", i, rf_wen, rf_waddr, rf_wdata, exp_addr[i], 10 + i); end
      tick();
      if (i == 0) begin
        #0;
        checks++; if (wb_allowin !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", wb_allowin); end
      end
      if (i == 1) idle_inputs();
      #1;
    end
    checks++; if (wb_valid !== 1'b0 || wb_allowin !== 1'b1) begin errors++;
      $display("FAIL bp_empty: got valid=%b allow=%b want 0/1", wb_valid, wb_allowin); end
  endtask

  task automatic test_load_align();
    logic [2:0]  lt   [6];
    logic [1:0]  lo2  [6];
    logic [3:0]  wen  [6];
    logic [31:0] expd [6];
    lt[0] = 3'd1; lo2[0] = 2'd3; wen[0] = 4'h1; expd[0] = 32'hFFFFFF80;
    lt[1] = 3'd2; lo2[1] = 2'd1; wen[1] = 4'hF; expd[1] = 32'h0000007F;
    lt[2] = 3'd3; lo2[2] = 2'd2; wen[2] = 4'hF; expd[2] = 32'hFFFF80FF;
    lt[3] = 3'd4; lo2[3] = 2'd0; wen[3] = 4'hF; expd[3] = 32'h00007F01;
    lt[4] = 3'd0; lo2[4] = 2'd0; wen[4] = 4'hF; expd[4] = 32'h80FF7F01;
    lt[5] = 3'd7; lo2[5] = 2'd2; wen[5] = 4'hF; expd[5] = 32'h80FF7F01;
    rf_ready = 1;
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      mem_valid = 1; mem_pc = 32'h200 + 32'(4 * i); mem_waddr = 5'd5; mem_wen = wen[i];
      mem_result = 32'hDEADBEEF; mem_is_load = 1; mem_load_type = lt[i];
      mem_addr_lo = lo2[i]; mem_rdata = 32'h80FF7F01;
      tick();
      idle_inputs();
      #1;
      checks++; if (rf_wen !== 4'hF || rf_wdata !== expd[i]) begin errors++;
        $display("FAIL load%0d: got wen=%h wdata=%h want F/%h", i, rf_wen, rf_wdata, expd[i]); end
      tick();
    end
  endtask

  task automatic test_r0_and_hi();
    rf_ready = 1;
    drive_alu(32'hbfc00100, 5'd0, 32'h55);
    tick();
    idle_inputs();
    mem_valid = 1; mem_pc = 32'hbfc00104; mem_hi_we = 1; mem_hi_wdata = 32'h1234;
    #1;
    checks++; if (rf_wen !== 4'h0 || wb_valid !== 1'b1 || debug_wb_pc !== 32'hbfc00100) begin errors++;
      $display("FAIL r0_retire: got wen=%h valid=%b pc=%h want 0/1/bfc00100", rf_wen, wb_valid, debug_wb_pc); end
    tick();
    idle_inputs();
    #1;
    checks++; if (debug_wb_pc !== 32'hbfc00104 || hi_o !== 32'h0) begin errors++;
      $display("FAIL mthi_pre: got pc=%h hi=%h want bfc00104/0", debug_wb_pc, hi_o); end
    tick();
    checks++; if (hi_o !== 32'h1234 || lo_o !== 32'h0) begin errors++;
      $display("FAIL mthi_post: got hi=%h lo=%h want 1234/0", hi_o, lo_o); end
  endtask

  task automatic test_forwarding();
    rf_ready = 0;
    fwd_raddr = 5'd9;
    drive_alu(32'h300, 5'd9, 32'd1);
    tick();
    drive_alu(32'h304, 5'd9, 32'd2);
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd1) begin errors++;
      $display("FAIL fwd_one: got hit=%b data=%h want 1/1", fwd_hit, fwd_data); end
    tick();
    idle_inputs();
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd2) begin errors++;
      $display("FAIL fwd_youngest: got hit=%b data=%h want 1/2", fwd_hit, fwd_data); end
    fwd_raddr = 5'd0;
    #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_r0: got %b want 0", fwd_hit); end
    fwd_raddr = 5'd8;
    #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss: got %b want 0", fwd_hit); end
    fwd_raddr = 5'd9;
    rf_ready = 1;
    #1;
    checks++; if (rf_wdata !== 32'd1 || rf_wen !== 4'hF) begin errors++;
      $display("FAIL fwd_retire1: got wdata=%h wen=%h want 1/F", rf_wdata, rf_wen); end
    tick();
    rf_ready = 0;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'd2) begin errors++;
      $display("FAIL fwd_after1: got hit=%b data=%h want 1/2", fwd_hit, fwd_data); end
    rf_ready = 1;
    tick();
    checks++; if (fwd_hit !== 1'b0 || wb_valid !== 1'b0) begin errors++;
      $display("FAIL fwd_after2: got hit=%b valid=%b want 0/0", fwd_hit, wb_valid); end
  endtask

  task automatic test_reset_midstream();
    rf_ready = 0;
    drive_alu(32'h400, 5'd6, 32'h66);
    mem_hi_we = 1; mem_hi_wdata = 32'hAAAA;
    tick();
    drive_alu(32'h404, 5'd7, 32'h77);
    mem_lo_we = 1; mem_lo_wdata = 32'hBBBB;
    tick();
    idle_inputs();
    #1;
    checks++; if (wb_allowin !== 1'b0 || hi_o !== 32'h1234) begin errors++;
      $display("FAIL mid_pre: got allow=%b hi=%h want 0/1234", wb_allowin, hi_o); end
    reset = 1;
    #1;
    checks++; if (wb_valid !== 1'b0 || wb_allowin !== 1'b1 || hi_o !== 32'h0) begin errors++;
      $display("FAIL mid_reset: got valid=%b allow=%b hi=%h want 0/1/0", wb_valid, wb_allowin, hi_o); end
    tick();
    reset = 0;
    rf_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rf_wen !== 4'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin errors++;
        $display("FAIL mid_after%0d: got wen=%h hi=%h lo=%h want 0/0/0", i, rf_wen, hi_o, lo_o); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_load_align();
    test_r0_and_hi();
    test_forwarding();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_retire_stage.md
Name: wb_retire_stage

Overview:
- Parametrised write-back stage for the 5-stage MIPS pipeline; sits between the memory stage and the register file, HI/LO, forwarding and debug-trace logic.
- Buffers up to DEPTH completed instructions in an in-order retire queue, so the register-file port can apply back-pressure (rf_ready) without stalling MEM for one cycle.
- Also performs load-data alignment and sign extension, HI/LO update at retire, $0 write suppression, and youngest-match forwarding from in-flight entries.

Parameters:
- DEPTH, 2, retire-queue entries; power of two, minimum 2.
- ADDR_W, 5, register address width.
- DATA_W, 32, datapath width; load alignment logic is defined for 32 only.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_valid  in  1  MEM stage holds a valid instruction.
- wb_allowin  out  1  queue can accept; equals (count != DEPTH).
- mem_pc  in  32  PC of the MEM instruction.
- mem_waddr  in  ADDR_W  destination register.
- mem_wen  in  4  byte write enables.
- mem_result  in  DATA_W  ALU/mul/div result.
- mem_is_load  in  1  instruction is a load.
- mem_load_type  in  3  0=LW 1=LB 2=LBU 3=LH 4=LHU; other codes are treated as LW.
- mem_addr_lo  in  2  low bits of the load address.
- mem_rdata  in  DATA_W  data SRAM read data, valid with mem_valid.
- mem_hi_we  in  1  write HI at retire.
- mem_lo_we  in  1  write LO at retire.
- mem_hi_wdata  in  DATA_W  data for HI.
- mem_lo_wdata  in  DATA_W  data for LO.
- rf_ready  in  1  register file / trace accepts the head entry this cycle.
- rf_wen  out  4  register-file byte enables.
- rf_waddr  out  ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- hi_o  out  DATA_W  architectural HI.
- lo_o  out  DATA_W  architectural LO.
- fwd_raddr  in  ADDR_W  forwarding lookup address.
- fwd_hit  out  1  a valid queued entry writes fwd_raddr.
- fwd_data  out  DATA_W  data from the youngest matching entry.
- wb_valid  out  1  queue non-empty.
- debug_wb_pc  out  32  trace PC.
- debug_wb_rf_wen  out  4  trace byte enables.
- debug_wb_rf_wnum  out  ADDR_W  trace register number.
- debug_wb_rf_wdata  out  DATA_W  trace write data.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Pointers and count go to 0; hi_o and lo_o go to 0.
  - All outputs are then 0, except wb_allowin, which is 1.
  - A reset asserted mid-operation discards all queued entries; HI/LO are not updated by discarded entries.
- Enqueue (enq) = mem_valid & wb_allowin.
  - On enq, one entry is written at the tail: pc, waddr, wen, data, hi/lo we and data.
  - Non-load: data = mem_result.
  - LB/LBU: data = byte at mem_addr_lo, sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: data = half selected by mem_addr_lo[1], sign-extended (LH) or zero-extended (LHU).
  - LW: data = mem_rdata.
  - Loads store wen = 4'hF when mem_wen != 0, else 0.
  - If waddr == 0, stored wen is forced to 0; the entry still retires.
- Retire (deq) = wb_valid & rf_ready; the head entry leaves the queue.
  - rf_wen = head wen gated by deq; rf_waddr and rf_wdata come from the head.
  - rf_wen = 0 whenever there is no deq.
  - On deq, HI/LO are loaded from the head if its hi_we/lo_we is set; the new value is visible the next cycle.
- Latency: an entry enqueued in cycle N can retire in cycle N+1 at the earliest. There is no combinational path from mem_* to rf_*.
- Count update:
  - enq & deq in the same cycle: count unchanged; both pointers advance.
  - enq only: count +1. deq only: count −1.
  - Pointers wrap modulo DEPTH.
- Full (count == DEPTH): wb_allowin = 0. MEM must hold its instruction; mem_valid is ignored. wb_allowin does not depend combinationally on rf_ready.
- Empty: wb_valid = 0, rf_wen = 0, fwd_hit = 0.
- Forwarding:
  - fwd_hit = OR over valid entries with waddr == fwd_raddr and wen != 0.
  - fwd_data comes from the youngest such entry; the same-cycle enq is not included.
  - fwd_raddr == 0 never hits.
- Debug trace:
  - debug_wb_rf_wen, debug_wb_rf_wnum and debug_wb_rf_wdata mirror rf_wen, rf_waddr and rf_wdata.
  - debug_wb_pc = head pc when wb_valid, else 0.

Test Plan:
- Reset mid-stream: fill 2 entries, assert reset -> wb_valid=0, wb_allowin=1, hi_o=0, no rf_wen pulse afterwards.
- rf_ready held 1, back-to-back ADDU writes to r3 (pc 0xbfc00000, data 5) and r4 (data 7) -> rf_wen=4'hF in the cycle after each enq, with the matching waddr and data.
- rf_ready=0 for 3 cycles with DEPTH=2 and continuous mem_valid -> wb_allowin drops after 2 enqueues. On release, retire order is preserved and count returns to 0.
- mem_rdata=0x80FF7F01, LB addr_lo=3 -> 0xFFFFFF80; LBU addr_lo=1 -> 0x0000007F; LH addr_lo=2 -> 0xFFFF80FF; LHU addr_lo=0 -> 0x00007F01.
- Write to r0 with wen=4'hF -> rf_wen=0 at retire, debug_wb_pc still shows the entry pc. MTHI 0x1234 -> hi_o=0x1234 in the cycle after retire.
- Two queued writes to r9 (data 1 then 2), fwd_raddr=9 -> fwd_hit=1, fwd_data=2. After the first retires, fwd_data is still 2; after both retire, fwd_hit=0.
